// File: rtl/scatter_pkg.sv
// Package: scatter_pkg
// Shared types and helpers for the outlier-column scatter controller.
//   scatter_state_t : sequencer states IDLE / RUN / DRAIN
//   count_zeros()   : number of small (0) entries in the low n bits of an
//                     indicator table, used to validate a new configuration
package scatter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scatter_state_t;

    // Widest indicator table the helper accepts; callers zero-extend.
    localparam int unsigned MAX_IN_SIZE = 64;
    localparam int unsigned ZW          = $clog2(MAX_IN_SIZE + 1);

    function automatic logic [ZW-1:0] count_zeros(input logic [MAX_IN_SIZE-1:0] tbl,
                                                  input int unsigned            n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_IN_SIZE; i++) begin
            if (i < n && !tbl[i]) begin
                cnt++;
            end
        end
        return cnt[ZW-1:0];
    endfunction

endpackage

// File: rtl/scatter_ctrl_if.sv
// Interface: scatter_ctrl_if
// Bundles the configuration, input stream, output stream and status signals
// of scatter_ctrl.
//   slave  modport : the controller side
//   master modport : the producer / consumer / configuration side
// Data arrays are row-major: element r*IN_SIZE+c is row r, column c.
interface scatter_ctrl_if #(
    parameter int unsigned IN_WIDTH       = 16,
    parameter int unsigned IN_SIZE        = 4,
    parameter int unsigned IN_PARALLELISM = 1,
    parameter int unsigned IN_DEPTH       = 8
);
    localparam int unsigned N  = IN_SIZE * IN_PARALLELISM;
    localparam int unsigned CW = $clog2(IN_DEPTH + 1);

    logic [IN_SIZE-1:0]         cfg_ind_table;
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic                       cfg_error;
    logic [IN_SIZE-1:0]         ind_table;

    logic [N-1:0][IN_WIDTH-1:0] data_in;
    logic                       data_in_valid;
    logic                       data_in_ready;

    logic [N-1:0][IN_WIDTH-1:0] data_out_large;
    logic [N-1:0][IN_WIDTH-1:0] data_out_small;
    logic                       data_out_valid;
    logic                       data_out_ready;

    logic                       tensor_done;
    logic [CW-1:0]              beat_count;

    modport slave (
        input  cfg_ind_table, cfg_valid, data_in, data_in_valid, data_out_ready,
        output cfg_ready, cfg_error, ind_table, data_in_ready,
               data_out_large, data_out_small, data_out_valid, tensor_done, beat_count
    );

    modport master (
        output cfg_ind_table, cfg_valid, data_in, data_in_valid, data_out_ready,
        input  cfg_ready, cfg_error, ind_table, data_in_ready,
               data_out_large, data_out_small, data_out_valid, tensor_done, beat_count
    );

endinterface

// File: rtl/scatter_mask_lane.sv
// Module: scatter_mask_lane
// Combinational split of one row of IN_SIZE elements by the indicator table.
//   ind_table : bit c = 1 -> column c goes to row_large, else to row_small
//   row_in    : input row
//   row_large : large-column elements, other positions zero
//   row_small : small-column elements, other positions zero
module scatter_mask_lane #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned IN_SIZE  = 4
) (
    input  logic [IN_SIZE-1:0]               ind_table,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] row_in,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0] row_large,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0] row_small
);

    always_comb begin
        row_large = '0;
        row_small = '0;
        for (int unsigned c = 0; c < IN_SIZE; c++) begin
            if (ind_table[c]) begin
                row_large[c] = row_in[c];
            end else begin
                row_small[c] = row_in[c];
            end
        end
    end

endmodule

// File: rtl/scatter_ctrl.sv
// Module: scatter_ctrl
// Sequencer and configuration owner for the outlier-column scatter datapath.
// Validates and latches a per-column large/small indicator table, then streams
// IN_DEPTH beats through a single output register, splitting each beat into
// large-column and small-column copies (non-selected entries zeroed).
// Ports:
//   clk : clock
//   rst : asynchronous reset, active-low
//   bus : scatter_ctrl_if.slave
//         cfg_ind_table/cfg_valid/cfg_ready/cfg_error : table load, error pulse
//         ind_table                                   : active table
//         data_in/data_in_valid/data_in_ready         : input beats
//         data_out_large/data_out_small/data_out_valid/data_out_ready : output beats
//         tensor_done : pulse after the last beat leaves; beat_count : beats accepted
// Build option:
//   SCATTER_CTRL_REUSE_TABLE_EN : when defined and cfg_valid is low at the
//   last-beat handoff, return straight to RUN with the same table.
module scatter_ctrl
    import scatter_pkg::*;
#(
    parameter int unsigned IN_WIDTH          = 16,
    parameter int unsigned IN_SIZE           = 4,
    parameter int unsigned IN_PARALLELISM    = 1,
    parameter int unsigned IN_DEPTH          = 8,
    parameter int unsigned OUT_LARGE_COLUMNS = 2,
    parameter int unsigned OUT_SMALL_COLUMNS = IN_SIZE - OUT_LARGE_COLUMNS
) (
    input  logic          clk,
    input  logic          rst,
    scatter_ctrl_if.slave bus
);

    localparam int unsigned    N         = IN_SIZE * IN_PARALLELISM;
    localparam int unsigned    CW        = $clog2(IN_DEPTH + 1);
    localparam logic [ZW-1:0]  SMALL_CNT = ZW'(OUT_SMALL_COLUMNS);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(IN_DEPTH - 1);

    scatter_state_t             state, state_next;
    logic [IN_SIZE-1:0]         table_q;
    logic [CW-1:0]              beat_q;
    logic                       cfg_error_q;
    logic                       done_q;
    logic                       out_valid_q;
    logic [N-1:0][IN_WIDTH-1:0] large_q, small_q;
    logic [N-1:0][IN_WIDTH-1:0] lane_large, lane_small;

    logic cfg_ready_c, in_ready_c;
    logic cfg_ok, cfg_take, accept, out_fire, last_accept, drain_done, reuse_hand;

    always_comb begin
        cfg_ok      = (count_zeros(MAX_IN_SIZE'(bus.cfg_ind_table), IN_SIZE) == SMALL_CNT);
        cfg_take    = (state == IDLE) && bus.cfg_valid && cfg_ok;
        accept      = bus.data_in_valid && in_ready_c;
        out_fire    = out_valid_q && bus.data_out_ready;
        last_accept = accept && (beat_q == LAST_BEAT);
        // The output register is empty after this edge: either already empty
        // or the last beat is being taken downstream right now.
        drain_done  = (state == DRAIN) && (!out_valid_q || bus.data_out_ready);
`ifdef SCATTER_CTRL_REUSE_TABLE_EN
        reuse_hand  = drain_done && !bus.cfg_valid;
`else
        reuse_hand  = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_take)    state_next = RUN;
            RUN:     if (last_accept) state_next = DRAIN;
            DRAIN:   if (drain_done)  state_next = reuse_hand ? RUN : IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        cfg_ready_c = (state == IDLE);
        in_ready_c  = (state == RUN) && (!out_valid_q || bus.data_out_ready);
    end

    // Table, beat counter and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            table_q     <= '0;
            beat_q      <= '0;
            cfg_error_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cfg_error_q <= (state == IDLE) && bus.cfg_valid && !cfg_ok;
            done_q      <= drain_done;
            if (cfg_take) begin
                table_q <= bus.cfg_ind_table;
                beat_q  <= '0;
            end else if (reuse_hand) begin
                beat_q  <= '0;
            end else if (accept) begin
                beat_q  <= beat_q + CW'(1);
            end
        end
    end

    for (genvar r = 0; r < IN_PARALLELISM; r++) begin : g_lane
        scatter_mask_lane #(
            .IN_WIDTH (IN_WIDTH),
            .IN_SIZE  (IN_SIZE)
        ) u_lane (
            .ind_table (table_q),
            .row_in    (bus.data_in[r*IN_SIZE +: IN_SIZE]),
            .row_large (lane_large[r*IN_SIZE +: IN_SIZE]),
            .row_small (lane_small[r*IN_SIZE +: IN_SIZE])
        );
    end

    // Output register: a new accept reloads it in the same cycle the old
    // contents drain, so back-to-back beats need no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            large_q     <= '0;
            small_q     <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            large_q     <= lane_large;
            small_q     <= lane_small;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.cfg_ready      = cfg_ready_c;
    assign bus.cfg_error      = cfg_error_q;
    assign bus.ind_table      = table_q;
    assign bus.data_in_ready  = in_ready_c;
    assign bus.data_out_large = large_q;
    assign bus.data_out_small = small_q;
    assign bus.data_out_valid = out_valid_q;
    assign bus.tensor_done    = done_q;
    assign bus.beat_count     = beat_q;

endmodule
